// File: rtl/game_sequencer.sv
// Phase controller for the flappy-bird game loop: IDLE -> COUNT -> PLAY -> DYING -> OVER,
// driving datapath run/restart and tracking mode plus the session high score.
module game_sequencer #(
   parameter int COUNT_TICKS = 30,
   parameter int DYING_TICKS = 20,
   parameter int OVER_HOLD   = 10,
   parameter int SCORE_W     = 16
) (
   input  logic               clk_100ms,
   input  logic               rst,
   input  logic               start_btn,
   input  logic               mode_btn,
   input  logic               fail,
   input  logic [SCORE_W-1:0] score,
   output logic               run,
   output logic               restart,
   output logic [2:0]         phase,
   output logic [1:0]         countdown,
   output logic               mode,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_record
);

   localparam int MAX_A     = (COUNT_TICKS > DYING_TICKS) ? COUNT_TICKS : DYING_TICKS;
   localparam int MAX_TICKS = (MAX_A > OVER_HOLD) ? MAX_A : OVER_HOLD;
   localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

   localparam logic [TIMER_W-1:0] T_COUNT = TIMER_W'(COUNT_TICKS - 1);
   localparam logic [TIMER_W-1:0] T_DYING = TIMER_W'(DYING_TICKS - 1);
   localparam logic [TIMER_W-1:0] T_OVER  = TIMER_W'(OVER_HOLD - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      PLAY  = 3'd2,
      DYING = 3'd3,
      OVER  = 3'd4
   } phase_t;

   phase_t               phase_reg;
   logic [TIMER_W-1:0]   timer_reg;
   logic                 start_q;
   logic                 mode_q;
   logic                 restart_reg;
   logic                 mode_reg;
   logic [SCORE_W-1:0]   high_score_reg;
   logic                 new_record_reg;
   logic                 start_rise;
   logic                 mode_rise;
   logic [TIMER_W-1:0]   countdown_full;

   assign start_rise = start_btn & ~start_q;
   assign mode_rise  = mode_btn & ~mode_q;

   always_ff @(posedge clk_100ms or negedge rst) begin
      if (!rst) begin
         phase_reg      <= IDLE;
         timer_reg      <= '0;
         start_q        <= 1'b0;
         mode_q         <= 1'b0;
         restart_reg    <= 1'b0;
         mode_reg       <= 1'b0;
         high_score_reg <= '0;
         new_record_reg <= 1'b0;
      end else begin
         start_q     <= start_btn;
         mode_q      <= mode_btn;
         restart_reg <= 1'b0;
         case (phase_reg)
            IDLE: begin
               if (mode_rise)
                  mode_reg <= ~mode_reg;
               if (start_rise) begin
                  phase_reg   <= COUNT;
                  timer_reg   <= T_COUNT;
                  restart_reg <= 1'b1;
               end
            end
            COUNT: begin
               if (timer_reg == '0)
                  phase_reg <= PLAY;
               else
                  timer_reg <= timer_reg - 1'b1;
            end
            PLAY: begin
               // Record is decided on the collision tick, from the score at that instant.
               if (fail) begin
                  phase_reg <= DYING;
                  timer_reg <= T_DYING;
                  if (score > high_score_reg) begin
                     high_score_reg <= score;
                     new_record_reg <= 1'b1;
                  end else begin
                     new_record_reg <= 1'b0;
                  end
               end
            end
            DYING: begin
               if (timer_reg == '0) begin
                  phase_reg <= OVER;
                  timer_reg <= T_OVER;
               end else begin
                  timer_reg <= timer_reg - 1'b1;
               end
            end
            OVER: begin
               // Presses during the hold-off are dropped rather than remembered.
               if (timer_reg != '0) begin
                  timer_reg <= timer_reg - 1'b1;
               end else if (start_rise) begin
                  phase_reg      <= COUNT;
                  timer_reg      <= T_COUNT;
                  restart_reg    <= 1'b1;
                  new_record_reg <= 1'b0;
               end
            end
            default: phase_reg <= IDLE;
         endcase
      end
   end

   assign countdown_full = timer_reg / TIMER_W'(10) + TIMER_W'(1);

   assign run        = (phase_reg == PLAY);
   assign restart    = restart_reg;
   assign phase      = phase_reg;
   assign countdown  = (phase_reg == COUNT) ? countdown_full[1:0] : 2'd0;
   assign mode       = mode_reg;
   assign high_score = high_score_reg;
   assign new_record = new_record_reg;

endmodule
